// File: rtl/bus_pkg.sv
// Shared defaults and FSM encoding for the round-robin burst arbiter.
package bus_pkg;

   localparam int DEF_BUS_SIZE  = 20;
   localparam int DEF_IDX_SIZE  = 4;
   localparam int DEF_IDX_COUNT = 4;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Rotating-priority search: first valid index at or after ptr, wrapping modulo IDX_COUNT.
// Latency: purely combinational; no backpressure involvement.
module rr_picker
   import bus_pkg::*;
#(
   parameter int IDX_SIZE  = DEF_IDX_SIZE,
   parameter int IDX_COUNT = DEF_IDX_COUNT
) (
   input  logic [IDX_SIZE-1:0]  ptr,
   input  logic [IDX_COUNT-1:0] valid,
   output logic [IDX_SIZE-1:0]  index,
   output logic                 found
);

   int pos;

   // Scan offsets from farthest to nearest so the nearest valid offset wins.
   always_comb begin
      index = '0;
      found = 1'b0;
      pos   = 0;
      for (int k = IDX_COUNT - 1; k >= 0; k--) begin
         pos = int'(ptr) + k;
         if (pos >= IDX_COUNT) begin
            pos = pos - IDX_COUNT;
         end
         for (int i = 0; i < IDX_COUNT; i++) begin
            if (valid[i] && (i == pos)) begin
               index = IDX_SIZE'(i);
               found = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin burst arbiter: a granted requester owns the bus until its last word.
// Latency: 1 cycle arbitration, 1 cycle req->out; out_ready low stalls req_ready of the grant.
module bus_arbiter
   import bus_pkg::*;
#(
   parameter int BUS_SIZE  = DEF_BUS_SIZE,
   parameter int IDX_SIZE  = DEF_IDX_SIZE,
   parameter int IDX_COUNT = DEF_IDX_COUNT
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [IDX_COUNT-1:0]          req_valid,
   input  logic [IDX_COUNT-1:0]          req_last,
   input  logic [IDX_COUNT*BUS_SIZE-1:0] req_data,
   output logic [IDX_COUNT-1:0]          req_ready,
   output logic                          out_valid,
   output logic [BUS_SIZE-1:0]           out_data,
   output logic [IDX_SIZE-1:0]           out_index,
   output logic                          out_last,
   input  logic                          out_ready,
   output logic                          busy
);

   arb_state_t state, state_nxt;
   logic [IDX_SIZE-1:0]  grant, grant_nxt;
   logic [IDX_SIZE-1:0]  ptr, ptr_nxt;
   logic [IDX_SIZE-1:0]  pick_idx;
   logic                 pick_found;
   logic [IDX_COUNT-1:0] grant_oh;
   logic [BUS_SIZE-1:0]  sel_data;
   logic                 sel_last;
   logic                 out_free;
   logic                 xfer;

   rr_picker #(
      .IDX_SIZE  (IDX_SIZE),
      .IDX_COUNT (IDX_COUNT)
   ) u_picker (
      .ptr   (ptr),
      .valid (req_valid),
      .index (pick_idx),
      .found (pick_found)
   );

   always_comb begin
      grant_oh = '0;
      sel_data = '0;
      for (int i = 0; i < IDX_COUNT; i++) begin
         grant_oh[i] = (grant == IDX_SIZE'(i));
         if (grant_oh[i]) begin
            sel_data = req_data[i*BUS_SIZE +: BUS_SIZE];
         end
      end
   end

   // The output register can take a new word when empty or draining this cycle.
   assign out_free  = !out_valid || out_ready;
   assign req_ready = ((state == LOCKED) && out_free) ? grant_oh : '0;
   assign xfer      = |(req_valid & req_ready);
   assign sel_last  = |(req_last & grant_oh);
   assign busy      = (state == LOCKED) || out_valid;

   always_comb begin
      state_nxt = state;
      grant_nxt = grant;
      ptr_nxt   = ptr;
      case (state)
         IDLE: begin
            if (pick_found) begin
               state_nxt = LOCKED;
               grant_nxt = pick_idx;
            end
         end
         LOCKED: begin
            if (xfer && sel_last) begin
               state_nxt = IDLE;
               ptr_nxt   = (grant == IDX_SIZE'(IDX_COUNT - 1)) ? '0 : grant + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         grant <= '0;
         ptr   <= '0;
      end else begin
         state <= state_nxt;
         grant <= grant_nxt;
         ptr   <= ptr_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_index <= '0;
         out_last  <= 1'b0;
      end else if (xfer) begin
         out_valid <= 1'b1;
         out_data  <= sel_data;
         out_index <= grant;
         out_last  <= sel_last;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 The block SHALL have parameter BUS_SIZE, default 20, width of one data word.
REQ-002 The block SHALL have parameter IDX_SIZE, default 4, width of a requester index.
REQ-003 The block SHALL have parameter IDX_COUNT, default 4, number of requesters; IDX_SIZE >= clog2(IDX_COUNT).
REQ-004 The block SHALL have one clock, clk, input, 1, with all state on its rising edge.
REQ-005 The block SHALL have rst, input, 1, asynchronous active-high reset.
REQ-006 The block SHALL have req_valid, input, IDX_COUNT, per-requester word valid.
REQ-007 The block SHALL have req_last, input, IDX_COUNT, per-requester final word of burst.
REQ-008 The block SHALL have req_data, input, IDX_COUNT*BUS_SIZE, with requester i at bits [i*BUS_SIZE +: BUS_SIZE].
REQ-009 The block SHALL have req_ready, output, IDX_COUNT, per-requester word accepted when high with req_valid.
REQ-010 The block SHALL have out_valid, output, 1, output register holds a word.
REQ-011 The block SHALL have out_data, output, BUS_SIZE, granted word.
REQ-012 The block SHALL have out_index, output, IDX_SIZE, source requester of out_data.
REQ-013 The block SHALL have out_last, output, 1, copy of req_last for that word.
REQ-014 The block SHALL have out_ready, input, 1, downstream accepts the word when high with out_valid.
REQ-015 The block SHALL have busy, output, 1, high when state is LOCKED or out_valid is high.

Function
REQ-016 The FSM SHALL have states IDLE and LOCKED, plus registers grant (IDX_SIZE) and ptr (IDX_SIZE).
REQ-017 In IDLE with any req_valid high, the block SHALL latch grant = first valid index searching ptr, ptr+1, ... mod IDX_COUNT, and enter LOCKED next cycle.
REQ-018 In IDLE, req_ready SHALL be all zero; arbitration latency is 1 cycle from req_valid to req_ready.
REQ-019 In LOCKED, only req_ready[grant] SHALL be high, and only when (!out_valid || out_ready).
REQ-020 A transfer (req_valid[grant] && req_ready[grant]) SHALL load out_data, out_last, and out_index = grant, and set out_valid next cycle.
REQ-021 When out_valid && out_ready with no transfer, out_valid SHALL clear next cycle; with a transfer in the same cycle, out_valid SHALL stay high with the new word.
REQ-022 While out_valid && !out_ready, out_data, out_index and out_last SHALL be held stable.
REQ-023 A transfer with req_last[grant]=1 SHALL return the FSM to IDLE and set ptr = grant+1, wrapping from IDX_COUNT-1 to 0.
REQ-024 When req_valid[grant] drops mid-burst, the grant SHALL be held indefinitely, with no timeout and no re-arbitration.
REQ-025 Between bursts, at least one IDLE cycle SHALL occur.
REQ-026 A continuously requesting requester SHALL wait at most IDX_COUNT-1 other bursts.
REQ-027 Non-granted requesters' req_valid, req_last and req_data SHALL have no effect.

Reset
REQ-028 On rst assertion, asynchronously: state=IDLE, ptr=0, grant=0, out_valid=0, out_data=0, out_index=0, out_last=0, req_ready=0, busy=0.
REQ-029 Reset mid-burst SHALL drop the burst and any held output word; after rst deasserts, arbitration SHALL restart from ptr=0.

Structure
REQ-030 Package bus_pkg SHALL hold BUS_SIZE, IDX_SIZE and IDX_COUNT defaults and the state enum (IDLE, LOCKED).
REQ-031 A combinational sub-module rr_picker (inputs ptr and valid vector; outputs index and found) SHALL implement the rotating priority search.
REQ-032 Data selection and output register SHALL be inline in bus_arbiter.

Verification
REQ-033 Single requester: req 2 sends 3 words 0x00001/0x00002/0x00003 (last on third), out_ready=1 -> out_index=2 for all three, out_last on third, then IDLE, ptr=3.
REQ-034 Round robin: all four request 1-word bursts continuously from ptr=0 -> grant order 0,1,2,3,0 with one IDLE cycle between.
REQ-035 Backpressure: out_ready=0 for 5 cycles mid-burst -> req_ready low, out_data stable, no word lost or duplicated.
REQ-036 Simultaneous drain and load: out_valid=1, out_ready=1, transfer same cycle -> out_valid stays 1 and out_data updates to the new word.
REQ-037 Reset mid-burst: rst pulse during the second word of a req 1 burst -> all outputs 0 immediately, and the next grant from ptr=0 picks the lowest valid.
